// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline definitions: EX/MEM control bundle and
// register-index constants used by the pipeline registers.
package cpu_pkg;

    // X31 reads as zero; writes to it are discarded, so it is never forwarded.
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       cbz;
        logic [3:0] xfer_size;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_en.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (takes priority over enable) and load enable.
module pipe_reg_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over enable so a bubble can be forced during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the pipelined LEGv8 CPU.
// Control bits are cleared on flush; data fields hold on flush so a
// bubble costs no data-path toggling. Both halves hold on stall.
// Optional performance counters: define EX_MEM_PERF_CNT_EN.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic          ex_regwrite,
    input  logic          ex_memwrite,
    input  logic          ex_memtoreg,
    input  logic          ex_branch,
    input  logic          ex_cbz,
    input  logic [3:0]    ex_xfer_size,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_zero,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_write_data,
    input  logic [DW-1:0] ex_new_pc2,
    output logic          mem_valid,
    output logic          mem_regwrite,
    output logic          mem_memwrite,
    output logic          mem_memtoreg,
    output logic          mem_branch,
    output logic          mem_cbz,
    output logic [3:0]    mem_xfer_size,
    output logic [RW-1:0] mem_rd,
    output logic          mem_zero,
    output logic [DW-1:0] mem_alu_result,
    output logic [DW-1:0] mem_write_data,
    output logic [DW-1:0] mem_new_pc2,
    output logic          fwd_en,
    output logic [RW-1:0] fwd_rd,
    output logic [31:0]   perf_instr,
    output logic [31:0]   perf_bubble,
    output logic [31:0]   perf_stall
);

    localparam int CW = 6;
    localparam int DATAW = 4 + RW + 1 + 3 * DW;

    ex_mem_ctrl_t     ex_ctrl;
    logic [CW-1:0]    ctrl_d;
    logic [CW-1:0]    ctrl_q;
    logic [DATAW-1:0] data_d;
    logic [DATAW-1:0] data_q;

    assign ex_ctrl = '{regwrite:  ex_regwrite,
                       memwrite:  ex_memwrite,
                       memtoreg:  ex_memtoreg,
                       branch:    ex_branch,
                       cbz:       ex_cbz,
                       xfer_size: ex_xfer_size};

    // An invalid EX slot must not leak side-effecting control into MEM.
    assign ctrl_d = ex_valid
        ? {1'b1, ex_ctrl.regwrite, ex_ctrl.memwrite, ex_ctrl.memtoreg,
           ex_ctrl.branch, ex_ctrl.cbz}
        : {1'b0, CTRL_BUBBLE.regwrite, CTRL_BUBBLE.memwrite,
           CTRL_BUBBLE.memtoreg, CTRL_BUBBLE.branch, CTRL_BUBBLE.cbz};

    assign data_d = {ex_ctrl.xfer_size, ex_rd, ex_zero,
                     ex_alu_result, ex_write_data, ex_new_pc2};

    pipe_reg_en #(.W(CW)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (~stall),
        .clr   (flush),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_reg_en #(.W(DATAW)) u_data_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (~stall & ~flush),
        .clr   (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    assign {mem_valid, mem_regwrite, mem_memwrite, mem_memtoreg,
            mem_branch, mem_cbz} = ctrl_q;

    assign {mem_xfer_size, mem_rd, mem_zero,
            mem_alu_result, mem_write_data, mem_new_pc2} = data_q;

    // Loads produce their value only after MEM, and XZR is never a real producer.
    assign fwd_en = mem_valid & mem_regwrite & ~mem_memtoreg &
                    (mem_rd != RW'(XZR_IDX));
    assign fwd_rd = mem_rd;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_stall_q;

    // Count edges by the same flush > stall > load priority as the register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_instr_q  <= '0;
            perf_bubble_q <= '0;
            perf_stall_q  <= '0;
        end else if (flush) begin
            perf_bubble_q <= perf_bubble_q + 32'd1;
        end else if (stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end else if (ex_valid) begin
            perf_instr_q <= perf_instr_q + 32'd1;
        end
    end

    assign perf_instr  = perf_instr_q;
    assign perf_bubble = perf_bubble_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_instr  = '0;
    assign perf_bubble = '0;
    assign perf_stall  = '0;
`endif

endmodule
